// File: rtl/fpga_puf_ctrl_pkg.sv
// Shared definitions for the PUF kernel AXI4-Lite control slave.
// Holds bus widths, the register map offsets, CTRL/IRQ bit positions,
// the OKAY response code, the write/read FSM state enums and a
// byte-enable merge helper used by the register file.
package fpga_puf_ctrl_pkg;

  localparam int unsigned C_S_AXI_ADDR_WIDTH = 6;
  localparam int unsigned C_S_AXI_DATA_WIDTH = 32;
  localparam int unsigned STRB_W             = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned ID_W               = 64;

  typedef logic [C_S_AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [C_S_AXI_DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_W-1:0]             strb_t;

  // Register map (byte offsets)
  localparam addr_t ADDR_CTRL  = 6'h00;
  localparam addr_t ADDR_GIE   = 6'h04;
  localparam addr_t ADDR_IER   = 6'h08;
  localparam addr_t ADDR_ISR   = 6'h0C;
  localparam addr_t ADDR_TRIG  = 6'h10;
  localparam addr_t ADDR_ID_LO = 6'h18;
  localparam addr_t ADDR_ID_HI = 6'h1C;

  // CTRL register bit positions
  localparam int unsigned CTRL_START        = 0;
  localparam int unsigned CTRL_DONE         = 1;
  localparam int unsigned CTRL_IDLE         = 2;
  localparam int unsigned CTRL_READY        = 3;
  localparam int unsigned CTRL_AUTO_RESTART = 7;

  // IER/ISR bit positions
  localparam int unsigned IRQ_DONE  = 0;
  localparam int unsigned IRQ_READY = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    WR_RESET = 2'd0,
    WR_IDLE  = 2'd1,
    WR_DATA  = 2'd2,
    WR_RESP  = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_RESET = 2'd0,
    RD_IDLE  = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic data_t apply_strb(input data_t old_v, input data_t new_v,
                                       input strb_t strb);
    data_t r;
    r = old_v;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fpga_puf_ctrl_s_axi_if.sv
// AXI4-Lite control bundle between the platform interconnect (master)
// and the PUF control slave (slave). Carries the five AXI4-Lite channels:
// AW (awvalid/awready/awaddr), W (wvalid/wready/wdata/wstrb),
// B (bvalid/bready/bresp), AR (arvalid/arready/araddr),
// R (rvalid/rready/rdata/rresp).
interface fpga_puf_ctrl_s_axi_if;
  import fpga_puf_ctrl_pkg::*;

  logic       awvalid;
  logic       awready;
  addr_t      awaddr;
  logic       wvalid;
  logic       wready;
  data_t      wdata;
  strb_t      wstrb;
  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;
  logic       arvalid;
  logic       arready;
  addr_t      araddr;
  logic       rvalid;
  logic       rready;
  data_t      rdata;
  logic [1:0] rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/fpga_puf_ctrl_s_axi.sv
// AXI4-Lite control slave for the PUF kernel top wrapper.
// Decodes host register accesses into ap_start, trig_o and id_o and
// reports ap_done/ap_idle/ap_ready status back to the host.
// Ports:
//   ap_clk, ap_rst_n     kernel clock, asynchronous active-low reset
//   s_axi_control        AXI4-Lite slave bundle (fpga_puf_ctrl_s_axi_if.slave)
//   interrupt            level interrupt (0 unless FPGA_PUF_CTRL_IRQ_EN)
//   ap_start             level start to the kernel wrapper
//   ap_done, ap_ready    kernel status pulses (sticky in CTRL, clear on read)
//   ap_idle              kernel idle level (read live)
//   trig_o, id_o         kernel arguments, straight from registers
// Build option: define FPGA_PUF_CTRL_IRQ_EN to add GIE/IER/ISR at
// 0x04/0x08/0x0C and drive interrupt; otherwise those offsets are unmapped.
module fpga_puf_ctrl_s_axi
  import fpga_puf_ctrl_pkg::*;
(
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  fpga_puf_ctrl_s_axi_if.slave        s_axi_control,
  output logic                        interrupt,
  output logic                        ap_start,
  input  logic                        ap_done,
  input  logic                        ap_idle,
  input  logic                        ap_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] trig_o,
  output logic [ID_W-1:0]             id_o
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic  awready_q, awready_d;
  logic  wready_q,  wready_d;
  logic  bvalid_q,  bvalid_d;
  logic  arready_q, arready_d;
  logic  rvalid_q,  rvalid_d;
  addr_t waddr_q,   waddr_d;
  data_t rdata_q,   rdata_d;
  data_t rd_mux_c;

  logic  ap_start_q,     ap_start_d;
  logic  auto_restart_q, auto_restart_d;
  logic  done_q,         done_d;
  logic  ready_q,        ready_d;
  data_t trig_q,         trig_d;
  data_t id_lo_q,        id_lo_d;
  data_t id_hi_q,        id_hi_d;

  logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
  logic ctrl_wr_c, ctrl_rd_c;

  // Handshake strobes; readies are state-decoded flops
  assign aw_hs_c   = awready_q && s_axi_control.awvalid;
  assign w_hs_c    = wready_q  && s_axi_control.wvalid;
  assign b_hs_c    = bvalid_q  && s_axi_control.bready;
  assign ar_hs_c   = arready_q && s_axi_control.arvalid;
  assign r_hs_c    = rvalid_q  && s_axi_control.rready;
  assign ctrl_wr_c = w_hs_c && (waddr_q == ADDR_CTRL) && s_axi_control.wstrb[0];
  assign ctrl_rd_c = ar_hs_c && (s_axi_control.araddr == ADDR_CTRL);

`ifdef FPGA_PUF_CTRL_IRQ_EN
  logic       gie_q, gie_d;
  logic [1:0] ier_q, ier_d;
  logic [1:0] isr_q, isr_d;
  logic       interrupt_q, interrupt_d;

  // Interrupt registers: ISR sets on enabled pulses (set beats toggle)
  always_comb begin
    gie_d       = gie_q;
    ier_d       = ier_q;
    isr_d       = isr_q;
    interrupt_d = gie_q & (|isr_q);
    if (w_hs_c && s_axi_control.wstrb[0]) begin
      if (waddr_q == ADDR_GIE) gie_d = s_axi_control.wdata[0];
      if (waddr_q == ADDR_IER) ier_d = s_axi_control.wdata[1:0];
      if (waddr_q == ADDR_ISR) isr_d = isr_q ^ s_axi_control.wdata[1:0];
    end
    if (ap_done  && ier_q[IRQ_DONE])  isr_d[IRQ_DONE]  = 1'b1;
    if (ap_ready && ier_q[IRQ_READY]) isr_d[IRQ_READY] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gie_q       <= 1'b0;
      ier_q       <= 2'b00;
      isr_q       <= 2'b00;
      interrupt_q <= 1'b0;
    end else begin
      gie_q       <= gie_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt = interrupt_q;
`else
  assign interrupt = 1'b0;
`endif

  // Read data mux; sticky bits are returned before this cycle's set
  always_comb begin
    rd_mux_c = '0;
    case (s_axi_control.araddr)
      ADDR_CTRL: begin
        rd_mux_c[CTRL_START]        = ap_start_q;
        rd_mux_c[CTRL_DONE]         = done_q;
        rd_mux_c[CTRL_IDLE]         = ap_idle;
        rd_mux_c[CTRL_READY]        = ready_q;
        rd_mux_c[CTRL_AUTO_RESTART] = auto_restart_q;
      end
`ifdef FPGA_PUF_CTRL_IRQ_EN
      ADDR_GIE:   rd_mux_c[0]   = gie_q;
      ADDR_IER:   rd_mux_c[1:0] = ier_q;
      ADDR_ISR:   rd_mux_c[1:0] = isr_q;
`endif
      ADDR_TRIG:  rd_mux_c = trig_q;
      ADDR_ID_LO: rd_mux_c = id_lo_q;
      ADDR_ID_HI: rd_mux_c = id_hi_q;
      default:    rd_mux_c = '0;
    endcase
  end

  // Write FSM: AW, then W, then B; one write outstanding
  always_comb begin
    wr_state_d = wr_state_q;
    waddr_d    = waddr_q;
    case (wr_state_q)
      WR_RESET: wr_state_d = WR_IDLE;
      WR_IDLE: begin
        if (aw_hs_c) begin
          waddr_d    = s_axi_control.awaddr;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA:  if (w_hs_c) wr_state_d = WR_RESP;
      WR_RESP:  if (b_hs_c) wr_state_d = WR_IDLE;
      default:  wr_state_d = WR_IDLE;
    endcase
    awready_d = (wr_state_d == WR_IDLE);
    wready_d  = (wr_state_d == WR_DATA);
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  // Read FSM: data captured at the AR handshake, held until rready
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_RESET: rd_state_d = RD_IDLE;
      RD_IDLE: begin
        if (ar_hs_c) begin
          rdata_d    = rd_mux_c;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA:  if (r_hs_c) rd_state_d = RD_IDLE;
      default:  rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = (rd_state_d == RD_DATA);
  end

  // Register file and kernel control bits
  always_comb begin
    trig_d         = trig_q;
    id_lo_d        = id_lo_q;
    id_hi_d        = id_hi_q;
    auto_restart_d = auto_restart_q;
    ap_start_d     = ap_start_q;
    done_d         = done_q;
    ready_d        = ready_q;

    if (w_hs_c) begin
      case (waddr_q)
        ADDR_TRIG:  trig_d  = apply_strb(trig_q,  s_axi_control.wdata, s_axi_control.wstrb);
        ADDR_ID_LO: id_lo_d = apply_strb(id_lo_q, s_axi_control.wdata, s_axi_control.wstrb);
        ADDR_ID_HI: id_hi_d = apply_strb(id_hi_q, s_axi_control.wdata, s_axi_control.wstrb);
        default: ;
      endcase
    end

    if (ctrl_wr_c) auto_restart_d = s_axi_control.wdata[CTRL_AUTO_RESTART];

    // ap_ready ends the run unless auto-restart; a host start write wins
    if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;
    if (ctrl_wr_c && s_axi_control.wdata[CTRL_START]) ap_start_d = 1'b1;

    // Clear-on-read of CTRL; a pulse in the same cycle wins
    if (ctrl_rd_c) begin
      done_d  = 1'b0;
      ready_d = 1'b0;
    end
    if (ap_done)  done_d  = 1'b1;
    if (ap_ready) ready_d = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state_q     <= WR_RESET;
      rd_state_q     <= RD_RESET;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      waddr_q        <= '0;
      rdata_q        <= '0;
      ap_start_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      trig_q         <= '0;
      id_lo_q        <= '0;
      id_hi_q        <= '0;
    end else begin
      wr_state_q     <= wr_state_d;
      rd_state_q     <= rd_state_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      bvalid_q       <= bvalid_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      waddr_q        <= waddr_d;
      rdata_q        <= rdata_d;
      ap_start_q     <= ap_start_d;
      auto_restart_q <= auto_restart_d;
      done_q         <= done_d;
      ready_q        <= ready_d;
      trig_q         <= trig_d;
      id_lo_q        <= id_lo_d;
      id_hi_q        <= id_hi_d;
    end
  end

  assign s_axi_control.awready = awready_q;
  assign s_axi_control.wready  = wready_q;
  assign s_axi_control.bvalid  = bvalid_q;
  assign s_axi_control.bresp   = RESP_OKAY;
  assign s_axi_control.arready = arready_q;
  assign s_axi_control.rvalid  = rvalid_q;
  assign s_axi_control.rdata   = rdata_q;
  assign s_axi_control.rresp   = RESP_OKAY;

  assign ap_start = ap_start_q;
  assign trig_o   = trig_q;
  assign id_o     = {id_hi_q, id_lo_q};

endmodule

// File: tb/tb_fpga_puf_ctrl_s_axi.sv
// Self-checking bench for fpga_puf_ctrl_s_axi: directed scenarios followed by
// random register traffic, checked against a register-map model; read data and
// write responses are checked by a monitor from an expectation queue.
`timescale 1ns/1ps
module tb_fpga_puf_ctrl_s_axi;
  import fpga_puf_ctrl_pkg::*;

`ifdef FPGA_PUF_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        interrupt;
  logic        ap_start;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b0;
  logic        ap_ready = 1'b0;
  logic [31:0] trig_o;
  logic [63:0] id_o;

  fpga_puf_ctrl_s_axi_if bus();

  fpga_puf_ctrl_s_axi dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axi_control (bus),
    .interrupt     (interrupt),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .trig_o        (trig_o),
    .id_o          (id_o)
  );

  always #5 ap_clk = ~ap_clk;

  // Model of the host-visible register state
  bit          m_start, m_done, m_rdy, m_auto, m_gie;
  bit   [1:0]  m_ier, m_isr;
  logic [31:0] m_trig;
  logic [63:0] m_id;

  int          total = 0;
  int          bad = 0;
  logic [31:0] rd_q[$];
  int          wr_pend = 0;

  logic [5:0]  addr_tab [10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10,
                                 6'h18, 6'h1C, 6'h14, 6'h3C, 6'h20};

  function automatic void model_reset();
    m_start = 0; m_done = 0; m_rdy = 0; m_auto = 0; m_gie = 0;
    m_ier = 0; m_isr = 0; m_trig = '0; m_id = '0;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] o, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      6'h00: v = {24'd0, m_auto, 3'd0, m_rdy, ap_idle, m_done, m_start};
      6'h04: v = IRQ_EN ? {31'd0, m_gie} : 32'd0;
      6'h08: v = IRQ_EN ? {30'd0, m_ier} : 32'd0;
      6'h0C: v = IRQ_EN ? {30'd0, m_isr} : 32'd0;
      6'h10: v = m_trig;
      6'h18: v = m_id[31:0];
      6'h1C: v = m_id[63:32];
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    case (a)
      6'h00: if (s[0]) begin
        if (d[0]) m_start = 1;
        m_auto = d[7];
      end
      6'h04: if (IRQ_EN && s[0]) m_gie = d[0];
      6'h08: if (IRQ_EN && s[0]) m_ier = d[1:0];
      6'h0C: if (IRQ_EN && s[0]) m_isr = m_isr ^ d[1:0];
      6'h10: m_trig = strb_merge(m_trig, d, s);
      6'h18: m_id[31:0]  = strb_merge(m_id[31:0], d, s);
      6'h1C: m_id[63:32] = strb_merge(m_id[63:32], d, s);
      default: ;
    endcase
  endfunction

  function automatic void model_done_pulse();
    m_done = 1;
    if (IRQ_EN && m_ier[0]) m_isr[0] = 1;
  endfunction

  function automatic void model_ready_pulse();
    m_rdy = 1;
    if (!m_auto) m_start = 0;
    if (IRQ_EN && m_ier[1]) m_isr[1] = 1;
  endfunction

  function automatic bit exp_irq();
    return IRQ_EN & m_gie & (|m_isr);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout got 0 expected 1", nm);
  endtask

  // All tasks are entered and left at a falling edge
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    while (bus.awready !== 1'b1 && n < 64) begin @(negedge ap_clk); n++; end
    if (n >= 64) begin timeout_fail("awready"); return; end
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    @(negedge ap_clk);
    bus.awvalid = 1'b0;
    n = 0;
    while (bus.wready !== 1'b1 && n < 64) begin @(negedge ap_clk); n++; end
    if (n >= 64) begin timeout_fail("wready"); return; end
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = s;
    model_write(a, d, s);
    wr_pend++;
    @(negedge ap_clk);
    bus.wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input bit with_done);
    int n;
    n = 0;
    while (bus.arready !== 1'b1 && n < 64) begin @(negedge ap_clk); n++; end
    if (n >= 64) begin timeout_fail("arready"); return; end
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    if (with_done) ap_done = 1'b1;
    rd_q.push_back(model_read(a));
    if (a == 6'h00) begin m_done = 0; m_rdy = 0; end
    if (with_done) model_done_pulse();
    @(negedge ap_clk);
    bus.arvalid = 1'b0;
    ap_done = 1'b0;
  endtask

  task automatic pulse(input bit is_ready);
    if (is_ready) begin ap_ready = 1'b1; model_ready_pulse(); end
    else begin ap_done = 1'b1; model_done_pulse(); end
    @(negedge ap_clk);
    ap_ready = 1'b0;
    ap_done  = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #1;
    rd_q.delete();
    wr_pend = 0;
    model_reset();
    check("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_ap_start", 64'(ap_start),   64'd0);
    check("rst_trig",    64'(trig_o),      64'd0);
    check("rst_id",      id_o,             64'd0);
    check("rst_irq",     64'(interrupt),   64'd0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_awready", 64'(bus.awready), 64'd1);
    check("post_rst_arready", 64'(bus.arready), 64'd1);
  endtask

  // Monitor: checks every presented read beat and write response
  initial begin
    forever begin
      @(negedge ap_clk);
      #1;
      if (ap_rst_n) begin
        if (bus.rvalid === 1'b1) begin
          if (rd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rvalid_unexpected: got rvalid=1 expected none");
          end else begin
            check("rdata", 64'(bus.rdata), 64'(rd_q[0]));
            check("rresp", 64'(bus.rresp), 64'(RESP_OKAY));
            if (bus.rready) void'(rd_q.pop_front());
          end
        end
        if (bus.bvalid === 1'b1 && bus.bready === 1'b1) begin
          if (wr_pend <= 0) begin
            total++; bad++;
            $display("FAIL bvalid_unexpected: got bvalid=1 expected none");
          end else begin
            check("bresp", 64'(bus.bresp), 64'(RESP_OKAY));
            wr_pend--;
          end
        end
      end
    end
  end

  initial begin
    int n;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready  = 1; bus.arvalid = 0; bus.araddr = '0; bus.rready = 1;
    model_reset();
    @(negedge ap_clk);
    do_reset();

    // Start, ready-clear and done sticky bit
    do_write(6'h00, 32'h1, 4'hF);
    check("start_set", 64'(ap_start), 64'(m_start));
    pulse(1'b1);
    check("start_clr_by_ready", 64'(ap_start), 64'(m_start));
    pulse(1'b0);
    do_read(6'h00, 1'b0);
    do_read(6'h00, 1'b0);

    // Arguments and byte strobes
    do_write(6'h18, 32'h89ABCDEF, 4'hF);
    do_write(6'h1C, 32'h01234567, 4'hF);
    check("id_o", id_o, 64'h0123456789ABCDEF);
    do_write(6'h10, 32'hFFFFFFFF, 4'b0010);
    check("trig_strb", 64'(trig_o), 64'h0000FF00);

    // Auto restart keeps ap_start through ready pulses
    do_write(6'h00, 32'h81, 4'hF);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1);
      check("auto_hold", 64'(ap_start), 64'(m_start));
    end
    do_write(6'h00, 32'h0, 4'hF);
    check("start_after_w0", 64'(ap_start), 64'(m_start));
    pulse(1'b1);
    check("start_clr_noauto", 64'(ap_start), 64'(m_start));

    // Done pulse coinciding with the CTRL read: old value read, bit stays set
    do_read(6'h00, 1'b0);
    do_read(6'h00, 1'b1);
    do_read(6'h00, 1'b0);

    // Write response back-pressure
    bus.bready = 1'b0;
    do_write(6'h10, 32'hA5A55A5A, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("bvalid_hold", 64'(bus.bvalid), 64'd1);
      check("awready_low", 64'(bus.awready), 64'd0);
      @(negedge ap_clk);
    end
    bus.bready = 1'b1;
    @(negedge ap_clk);

    // Read back-pressure and unmapped read
    bus.rready = 1'b0;
    do_read(6'h10, 1'b0);
    repeat (5) @(negedge ap_clk);
    bus.rready = 1'b1;
    @(negedge ap_clk);
    do_read(6'h3C, 1'b0);

    // Interrupt path (stays 0 without the IRQ build)
    do_write(6'h04, 32'h1, 4'hF);
    do_write(6'h08, 32'h1, 4'hF);
    pulse(1'b0);
    @(negedge ap_clk);
    check("irq_set", 64'(interrupt), 64'(exp_irq()));
    do_write(6'h0C, 32'h1, 4'hF);
    @(negedge ap_clk);
    check("irq_clr", 64'(interrupt), 64'(exp_irq()));

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      int op;
      logic [5:0] a;
      op = int'($urandom_range(0, 4));
      a  = addr_tab[$urandom_range(0, 9)];
      ap_idle = 1'($urandom_range(0, 1));
      case (op)
        0, 1: do_write(a, $urandom, 4'($urandom_range(0, 15)));
        2: do_read(a, 1'b0);
        3: pulse(1'b0);
        default: pulse(1'b1);
      endcase
      @(negedge ap_clk);
      check("rnd_trig", 64'(trig_o), 64'(m_trig));
      check("rnd_id", id_o, m_id);
      check("rnd_start", 64'(ap_start), 64'(m_start));
      check("rnd_irq", 64'(interrupt), 64'(exp_irq()));
    end

    // Reset while a write response is pending
    n = 0;
    while ((rd_q.size() != 0 || wr_pend != 0) && n < 100) begin @(negedge ap_clk); n++; end
    bus.bready = 1'b0;
    do_write(6'h18, 32'hDEADBEEF, 4'hF);
    check("bvalid_before_rst", 64'(bus.bvalid), 64'd1);
    do_reset();
    bus.bready = 1'b1;
    @(negedge ap_clk);
    check("bvalid_after_rst", 64'(bus.bvalid), 64'd0);
    do_read(6'h18, 1'b0);

    // Drain outstanding responses
    n = 0;
    while ((rd_q.size() != 0 || wr_pend != 0) && n < 100) begin @(negedge ap_clk); n++; end
    if (n >= 100) timeout_fail("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
